// File: rtl/dac_arb_defs.sv
// Shared definitions for the DAC arbiter (and the planned ADC arbiter).
// FSM state encodings and a modulo-increment helper for pointers.
package dac_arb_defs;

  localparam int STATE_WID = 2;

  localparam logic [STATE_WID-1:0] IDLE = 2'd0;
  localparam logic [STATE_WID-1:0] ARM  = 2'd1;
  localparam logic [STATE_WID-1:0] DONE = 2'd2;
  localparam logic [STATE_WID-1:0] GAP  = 2'd3;

  // (idx + 1) mod n, for round-robin pointers.
  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dac_arbiter_if.sv
// Requester and SPI-master handshake bundle for dac_arbiter.
// master: arbiter side; slave: requesters + SPI master side.
interface dac_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DAC_WID = 24
);

  logic [NUM_REQ-1:0]         req_arm;
  logic [NUM_REQ*DAC_WID-1:0] req_to_dac;
  logic [NUM_REQ*DAC_WID-1:0] req_from_dac;
  logic [NUM_REQ-1:0]         req_finished;
  logic [NUM_REQ-1:0]         req_lock;

  logic               dac_arm;
  logic [DAC_WID-1:0] dac_to_dac;
  logic [DAC_WID-1:0] dac_from_dac;
  logic               dac_finished;

  modport master (
    input  req_arm,
    input  req_to_dac,
    input  req_lock,
    input  dac_from_dac,
    input  dac_finished,
    output req_from_dac,
    output req_finished,
    output dac_arm,
    output dac_to_dac
  );

  modport slave (
    output req_arm,
    output req_to_dac,
    output req_lock,
    output dac_from_dac,
    output dac_finished,
    input  req_from_dac,
    input  req_finished,
    input  dac_arm,
    input  dac_to_dac
  );

endinterface

// File: rtl/dac_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr.
// Ports: req (N), ptr (W) in; found, idx (W) out. Assumes ptr < N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int         j;
  logic [W-1:0] jw;

  // Scan offsets from far to near so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jw    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jw = W'(j);
      if (req[jw]) begin
        found = 1'b1;
        idx   = jw;
      end
    end
  end

endmodule

// File: rtl/dac_arbiter.sv
// Shares one DAC SPI master among NUM_REQ requesters, round-robin per
// transaction, with a forced idle gap between consecutive SPI commands.
// Ports: clk, rst (sync, active-high); bus (dac_arbiter_if.master) with
// per-requester arm/to_dac/from_dac/finished/lock and the SPI master
// handshake; busy (state != IDLE); grant (current or last owner).
// Optional: define DAC_ARB_LOCK_EN to let req_lock keep the bus for
// consecutive transactions of one requester.
module dac_arbiter
  import dac_arb_defs::*;
#(
  parameter int NUM_REQ          = 3,
  parameter int DAC_WID          = 24,
  parameter int WAIT_BETWEEN_CMD = 10,
  parameter int TIMER_WID        = 4,
  parameter int GRANT_WID        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_arbiter_if.master        bus,
  output logic                 busy,
  output logic [GRANT_WID-1:0] grant
);

  localparam logic [TIMER_WID-1:0] GAP_LAST =
    TIMER_WID'(WAIT_BETWEEN_CMD > 0 ? WAIT_BETWEEN_CMD - 1 : 0);

  logic [STATE_WID-1:0] state;
  logic [GRANT_WID-1:0] ptr;
  logic [GRANT_WID-1:0] nxt;
  logic [GRANT_WID-1:0] pick_idx;
  logic [GRANT_WID-1:0] take_idx;
  logic [TIMER_WID-1:0] cnt;
  logic                 found;
  logic                 take;
  logic                 aborted;
  logic                 done_exit;
  logic                 gap_exit;
  logic                 lock_on;
  logic                 keep_ptr;

  rr_pick #(
    .N (NUM_REQ),
    .W (GRANT_WID)
  ) u_pick (
    .req   (bus.req_arm),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign nxt = GRANT_WID'(wrap_inc(int'(grant), NUM_REQ));
  assign busy = (state != IDLE);

  assign done_exit = (state == DONE)
                   && !bus.req_arm[grant]
                   && !bus.dac_finished;

  assign gap_exit = (state == GAP) && (cnt == GAP_LAST);

`ifdef DAC_ARB_LOCK_EN
  logic lock;

  // With no gap the owner has no window to re-arm before IDLE,
  // so a lock could only starve the others; it never engages then.
  assign keep_ptr = bus.req_lock[grant]
                  && (WAIT_BETWEEN_CMD != 0);
  assign lock_on  = lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (done_exit) begin
      lock <= keep_ptr;
    end else if (gap_exit && !bus.req_arm[grant]) begin
      lock <= 1'b0;
    end
  end
`else
  assign keep_ptr = 1'b0;
  assign lock_on  = 1'b0;

  wire unused_lock = &{1'b0, bus.req_lock};
`endif

  // A held lock re-grants only the owner and ignores everyone else.
  always_comb begin
    take     = found;
    take_idx = pick_idx;
    if (lock_on) begin
      take     = bus.req_arm[grant];
      take_idx = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      grant            <= '0;
      ptr              <= '0;
      cnt              <= '0;
      aborted          <= 1'b0;
      bus.dac_arm      <= 1'b0;
      bus.dac_to_dac   <= '0;
      bus.req_from_dac <= '0;
      bus.req_finished <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant          <= take_idx;
            bus.dac_to_dac <= bus.req_to_dac[
              int'(take_idx)*DAC_WID +: DAC_WID];
            bus.dac_arm    <= 1'b1;
            aborted        <= 1'b0;
            state          <= ARM;
          end
        end
        ARM: begin
          // The SPI transfer cannot be aborted; a dropped arm only
          // suppresses the finished pulse.
          if (!bus.req_arm[grant]) aborted <= 1'b1;
          if (bus.dac_finished) begin
            bus.req_from_dac[int'(grant)*DAC_WID +: DAC_WID]
              <= bus.dac_from_dac;
            bus.dac_arm <= 1'b0;
            bus.req_finished[grant]
              <= bus.req_arm[grant] && !aborted;
            state <= DONE;
          end
        end
        DONE: begin
          if (done_exit) begin
            bus.req_finished[grant] <= 1'b0;
            ptr   <= keep_ptr ? grant : nxt;
            cnt   <= '0;
            state <= (WAIT_BETWEEN_CMD == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (gap_exit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_arbiter.sv
// Directed self-checking bench for dac_arbiter: main build (gap 10)
// plus a second instance built with no inter-command gap.
module tb_dac_arbiter;

  localparam int N = 3;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy0;
  logic [1:0] grant, grant0;

  int checks = 0;
  int fails  = 0;

  logic          fixed_en;
  logic [W-1:0]  fixed_val;
  int            scnt, scnt0;

  always #5 clk = ~clk;

  dac_arbiter_if #(.NUM_REQ(N), .DAC_WID(W)) bus ();
  dac_arbiter_if #(.NUM_REQ(N), .DAC_WID(W)) bus0 ();

  dac_arbiter #(
    .NUM_REQ(N), .DAC_WID(W), .WAIT_BETWEEN_CMD(10),
    .TIMER_WID(4), .GRANT_WID(2)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .grant(grant)
  );

  dac_arbiter #(
    .NUM_REQ(N), .DAC_WID(W), .WAIT_BETWEEN_CMD(0),
    .TIMER_WID(4), .GRANT_WID(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .grant(grant0)
  );

  // SPI master models: finish 5 cycles after arm, hold until arm falls.
  initial begin
    bus.dac_finished = 1'b0;
    bus.dac_from_dac = '0;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!bus.dac_arm) begin
        bus.dac_finished = 1'b0;
        scnt = 0;
      end else if (!bus.dac_finished) begin
        scnt++;
        if (scnt == 5) begin
          bus.dac_finished = 1'b1;
          bus.dac_from_dac = fixed_en ? fixed_val : ~bus.dac_to_dac;
        end
      end
    end
  end

  initial begin
    bus0.dac_finished = 1'b0;
    bus0.dac_from_dac = '0;
    scnt0 = 0;
    forever begin
      @(negedge clk);
      if (!bus0.dac_arm) begin
        bus0.dac_finished = 1'b0;
        scnt0 = 0;
      end else if (!bus0.dac_finished) begin
        scnt0++;
        if (scnt0 == 5) begin
          bus0.dac_finished = 1'b1;
          bus0.dac_from_dac = ~bus0.dac_to_dac;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req_arm = '0;
    bus.req_lock = '0;
    bus0.req_arm = '0;
    bus0.req_lock = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus.dac_arm !== 1'b0) begin
      fails++;
      $display("FAIL reset_arm: got %0b want 0", bus.dac_arm);
    end
    checks++;
    if (bus.req_finished !== 3'b000) begin
      fails++;
      $display("FAIL reset_fin: got %b want 000", bus.req_finished);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (grant !== 2'd0) begin
      fails++;
      $display("FAIL reset_grant: got %0d want 0", grant);
    end
    checks++;
    if (bus.req_from_dac !== '0 || bus.dac_to_dac !== '0) begin
      fails++;
      $display("FAIL reset_data: from %h to %h want 0",
               bus.req_from_dac, bus.dac_to_dac);
    end
  endtask

  task automatic test_single;
    int t;
    do_reset();
    fixed_en = 1'b1;
    fixed_val = 24'h900000;
    bus.req_to_dac = {24'h333333, 24'h1ABCDE, 24'h000111};
    bus.req_arm = 3'b010;
    tick(1);
    checks++;
    if (bus.dac_arm !== 1'b1 || bus.dac_to_dac !== 24'h1ABCDE) begin
      fails++;
      $display("FAIL single_arm: arm %0b word %h want 1 1abcde",
               bus.dac_arm, bus.dac_to_dac);
    end
    checks++;
    if (grant !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant %0d busy %0b want 1 1",
               grant, busy);
    end
    t = 0;
    while (!bus.req_finished[1] && t < 50) begin
      tick(1);
      t++;
    end
    checks++;
    if (bus.req_finished !== 3'b010) begin
      fails++;
      $display("FAIL single_fin: got %b want 010", bus.req_finished);
    end
    checks++;
    if (bus.req_from_dac[47:24] !== 24'h900000) begin
      fails++;
      $display("FAIL single_rdbk: got %h want 900000",
               bus.req_from_dac[47:24]);
    end
    tick(3);
    checks++;
    if (bus.req_finished !== 3'b010 || bus.dac_arm !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: fin %b arm %0b want 010 0",
               bus.req_finished, bus.dac_arm);
    end
    bus.req_arm = 3'b001;
    tick(1);
    checks++;
    if (bus.req_finished !== 3'b000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_drop: fin %b busy %0b want 000 1",
               bus.req_finished, busy);
    end
    tick(10);
    checks++;
    if (bus.dac_arm !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_gap: arm %0b busy %0b want 0 0",
               bus.dac_arm, busy);
    end
    tick(1);
    checks++;
    if (bus.dac_arm !== 1'b1 || grant !== 2'd0
        || bus.dac_to_dac !== 24'h000111) begin
      fails++;
      $display("FAIL single_next: arm %0b grant %0d word %h want 1 0 111",
               bus.dac_arm, grant, bus.dac_to_dac);
    end
    bus.req_arm = 3'b000;
    tick(20);
  endtask

  task automatic test_round_robin;
    logic [W-1:0] words [3];
    logic [W-1:0] exp_word;
    int t, exp, obs, multi;
    do_reset();
    fixed_en = 1'b0;
    words[0] = 24'hA00000;
    words[1] = 24'hB00001;
    words[2] = 24'hC00002;
    bus.req_to_dac = {words[2], words[1], words[0]};
    bus.req_arm = 3'b111;
    multi = 0;
    for (int k = 0; k < 6; k++) begin
      exp = k % 3;
      t = 0;
      while (bus.req_finished == 3'b000 && t < 100) begin
        tick(1);
        t++;
      end
      if ($countones(bus.req_finished) > 1) multi++;
      checks++;
      if (bus.req_finished !== (3'b001 << exp)) begin
        fails++;
        $display("FAIL rr_order[%0d]: fin %b want one-hot bit %0d",
                 k, bus.req_finished, exp);
      end
      exp_word = ~words[exp];
      checks++;
      if (bus.req_from_dac[exp*W +: W] !== exp_word) begin
        fails++;
        $display("FAIL rr_rdbk[%0d]: got %h want %h",
                 k, bus.req_from_dac[exp*W +: W], exp_word);
      end
      obs = bus.req_finished[0] ? 0 : bus.req_finished[1] ? 1 : 2;
      bus.req_arm[obs] = 1'b0;
      tick(1);
      bus.req_arm[obs] = 1'b1;
    end
    checks++;
    if (multi != 0) begin
      fails++;
      $display("FAIL rr_onehot: %0d multi-hot samples want 0", multi);
    end
    bus.req_arm = 3'b000;
    tick(30);
  endtask

  task automatic test_abort;
    int t, fin_seen;
    do_reset();
    fixed_en = 1'b1;
    fixed_val = 24'h5A5A5A;
    bus.req_to_dac = {24'h222222, 24'h111111, 24'h000000};
    bus.req_arm = 3'b100;
    t = 0;
    while (!bus.dac_arm && t < 20) begin
      tick(1);
      t++;
    end
    checks++;
    if (grant !== 2'd2 || bus.dac_arm !== 1'b1) begin
      fails++;
      $display("FAIL abort_grant: grant %0d arm %0b want 2 1",
               grant, bus.dac_arm);
    end
    tick(2);
    bus.req_arm = 3'b000;
    fin_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (bus.req_finished != 3'b000) fin_seen++;
    end
    checks++;
    if (fin_seen != 0) begin
      fails++;
      $display("FAIL abort_fin: finished seen %0d cycles want 0",
               fin_seen);
    end
    checks++;
    if (bus.req_from_dac[71:48] !== 24'h5A5A5A) begin
      fails++;
      $display("FAIL abort_rdbk: got %h want 5a5a5a",
               bus.req_from_dac[71:48]);
    end
    checks++;
    if (busy !== 1'b0 || bus.dac_arm !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy %0b arm %0b want 0 0",
               busy, bus.dac_arm);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    do_reset();
    fixed_en = 1'b1;
    fixed_val = 24'h777777;
    bus.req_to_dac = {24'hC2C2C2, 24'hB1B1B1, 24'hA0A0A0};
    bus.req_arm = 3'b010;
    tick(2);
    checks++;
    if (bus.dac_arm !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: arm %0b want 1", bus.dac_arm);
    end
    rst = 1'b1;
    bus.req_arm = 3'b000;
    tick(1);
    checks++;
    if (bus.dac_arm !== 1'b0 || bus.req_finished !== 3'b000
        || busy !== 1'b0 || grant !== 2'd0) begin
      fails++;
      $display("FAIL rmid_reset: arm %0b fin %b busy %0b grant %0d",
               bus.dac_arm, bus.req_finished, busy, grant);
    end
    rst = 1'b0;
    bus.req_arm = 3'b100;
    tick(1);
    checks++;
    if (bus.dac_arm !== 1'b1 || grant !== 2'd2
        || bus.dac_to_dac !== 24'hC2C2C2) begin
      fails++;
      $display("FAIL rmid_regrant: arm %0b grant %0d word %h",
               bus.dac_arm, grant, bus.dac_to_dac);
    end
    t = 0;
    while (!bus.req_finished[2] && t < 50) begin
      tick(1);
      t++;
    end
    checks++;
    if (bus.req_finished !== 3'b100
        || bus.req_from_dac[71:48] !== 24'h777777) begin
      fails++;
      $display("FAIL rmid_serve: fin %b rdbk %h want 100 777777",
               bus.req_finished, bus.req_from_dac[71:48]);
    end
    bus.req_arm = 3'b000;
    tick(20);
  endtask

  task automatic test_no_gap;
    int t;
    do_reset();
    bus0.req_to_dac = {24'h000000, 24'h0000B1, 24'h0000A0};
    bus0.req_arm = 3'b011;
    t = 0;
    while (!bus0.req_finished[0] && t < 50) begin
      tick(1);
      t++;
    end
    checks++;
    if (bus0.req_finished !== 3'b001 || grant0 !== 2'd0
        || bus0.req_from_dac[23:0] !== 24'hFFFF5F) begin
      fails++;
      $display("FAIL nogap_first: fin %b grant %0d rdbk %h",
               bus0.req_finished, grant0, bus0.req_from_dac[23:0]);
    end
    bus0.req_arm[0] = 1'b0;
    tick(1);
    checks++;
    if (busy0 !== 1'b0 || bus0.dac_arm !== 1'b0) begin
      fails++;
      $display("FAIL nogap_idle: busy %0b arm %0b want 0 0",
               busy0, bus0.dac_arm);
    end
    tick(1);
    checks++;
    if (bus0.dac_arm !== 1'b1 || grant0 !== 2'd1
        || bus0.dac_to_dac !== 24'h0000B1) begin
      fails++;
      $display("FAIL nogap_next: arm %0b grant %0d word %h",
               bus0.dac_arm, grant0, bus0.dac_to_dac);
    end
    bus0.req_arm = 3'b000;
    tick(20);
  endtask

  task automatic test_lock;
    int exp_g [3];
    int t, obs, c0;
`ifdef DAC_ARB_LOCK_EN
    exp_g = '{0, 0, 1};
`else
    exp_g = '{0, 1, 0};
`endif
    do_reset();
    fixed_en = 1'b0;
    bus.req_to_dac = {24'h000C00, 24'h000B00, 24'h000A00};
    bus.req_lock = 3'b001;
    bus.req_arm = 3'b011;
    c0 = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (bus.req_finished == 3'b000 && t < 100) begin
        tick(1);
        t++;
      end
      obs = bus.req_finished[0] ? 0 : bus.req_finished[1] ? 1 :
            bus.req_finished[2] ? 2 : 7;
      checks++;
      if (obs != exp_g[k]) begin
        fails++;
        $display("FAIL lock_order[%0d]: got %0d want %0d",
                 k, obs, exp_g[k]);
      end
      if (obs > 2) break;
      bus.req_arm[obs] = 1'b0;
      if (obs == 0) begin
        c0++;
        if (c0 == 2) bus.req_lock[0] = 1'b0;
      end
      tick(1);
      if (obs == 0 && c0 == 1) bus.req_arm[0] = 1'b1;
    end
    bus.req_arm = 3'b000;
    bus.req_lock = 3'b000;
    tick(20);
  endtask

  initial begin
    rst = 1'b1;
    fixed_en = 1'b0;
    fixed_val = '0;
    bus.req_arm = '0;
    bus.req_lock = '0;
    bus.req_to_dac = '0;
    bus0.req_arm = '0;
    bus0.req_lock = '0;
    bus0.req_to_dac = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_no_gap();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
